// File: rtl/feature_burst_buffer_if.sv
// ============================================================================
// feature_burst_buffer_if : burst-write / FWFT-read handshake bundle
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 512
`endif

interface feature_burst_buffer_if #(
    parameter int MEM_DATA_WIDTH = `MEM_DATA_WIDTH
) ();

    logic [MEM_DATA_WIDTH-1:0] in_data;
    logic                      in_valid;
    logic                      buffer_ready;
    logic                      burst_done;
    logic [MEM_DATA_WIDTH-1:0] out_data;
    logic                      out_valid;
    logic                      out_ready;

    // master: DDR reader plus conv input stage around the buffer
    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  buffer_ready,
        input  burst_done,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output buffer_ready,
        output burst_done,
        output out_data,
        output out_valid
    );

endinterface

`default_nettype wire

// File: rtl/feature_burst_buffer.sv
// ============================================================================
// feature_burst_buffer : circular feature staging buffer, burst-granular ready
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 512
`endif

module feature_burst_buffer #(
    parameter int MEM_DATA_WIDTH = `MEM_DATA_WIDTH,
    parameter int DEPTH          = 256,
    parameter int BURST_LEN      = 64,
    parameter int CNT_W          = $clog2(DEPTH) + 1
) (
    input  wire                         system_clk,
    input  wire                         rst_n,
    input  wire                         clear,
    feature_burst_buffer_if.slave       bus,
    output logic [CNT_W-1:0]            level,
    output logic                        overflow
);

    localparam int                 c_aw        = $clog2(DEPTH);
    localparam int                 c_bw        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0]   c_depth     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]   c_burst_len = CNT_W'(BURST_LEN);
    localparam logic [c_bw-1:0]    c_last_beat = c_bw'(BURST_LEN - 1);

    logic [MEM_DATA_WIDTH-1:0] mem [DEPTH];

    logic [c_aw-1:0]           wr_ptr_q,       wr_ptr_d;
    logic [c_aw-1:0]           rd_ptr_q,       rd_ptr_d;
    logic [CNT_W-1:0]          level_q,        level_d;
    logic [c_bw-1:0]           beat_cnt_q,     beat_cnt_d;
    logic                      buffer_ready_q, buffer_ready_d;
    logic                      burst_done_q,   burst_done_d;
    logic                      overflow_q,     overflow_d;
    logic                      out_valid_q,    out_valid_d;
    logic [MEM_DATA_WIDTH-1:0] out_data_q,     out_data_d;
    logic                      skid_valid_q,   skid_valid_d;
    logic [MEM_DATA_WIDTH-1:0] skid_data_q,    skid_data_d;

    logic                      wr_acc;
    logic                      pop;
    logic                      rd_en;
    logic [CNT_W-1:0]          unread;
    logic [1:0]                held_after_pop;
    logic [MEM_DATA_WIDTH-1:0] mem_rdata;

    // Full is judged on the registered level, so a same-cycle pop never frees a slot.
    assign wr_acc = bus.in_valid && (level_q != c_depth) && !clear;
    assign pop    = out_valid_q && bus.out_ready;

    // Beats still in the array = total held minus those in out/skid registers.
    assign unread         = level_q - CNT_W'(out_valid_q) - CNT_W'(skid_valid_q);
    assign held_after_pop = {1'b0, out_valid_q} + {1'b0, skid_valid_q} - {1'b0, pop};
    assign rd_en          = (unread != '0) && (held_after_pop < 2'd2) && !clear;
    assign mem_rdata      = mem[rd_ptr_q];

    always_ff @(posedge system_clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= bus.in_data;
        end
    end

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        level_d        = level_q;
        beat_cnt_d     = beat_cnt_q;
        buffer_ready_d = buffer_ready_q;
        burst_done_d   = 1'b0;
        overflow_d     = overflow_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        skid_valid_d   = skid_valid_q;
        skid_data_d    = skid_data_q;

        if (clear) begin
            wr_ptr_d       = '0;
            rd_ptr_d       = '0;
            level_d        = '0;
            beat_cnt_d     = '0;
            buffer_ready_d = 1'b1;
            overflow_d     = 1'b0;
            out_valid_d    = 1'b0;
            skid_valid_d   = 1'b0;
        end else begin
            level_d        = level_q + CNT_W'(wr_acc) - CNT_W'(pop);
            buffer_ready_d = (c_depth - level_d) >= c_burst_len;

            if (bus.in_valid && (level_q == c_depth)) begin
                overflow_d = 1'b1;
            end

            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (beat_cnt_q == c_last_beat) begin
                    beat_cnt_d   = '0;
                    burst_done_d = 1'b1;
                end else begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end

            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end

            // Output register refills on the pop cycle; skid absorbs the read issued during a stall.
            if (pop || !out_valid_q) begin
                if (skid_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_data_d   = skid_data_q;
                    skid_valid_d = rd_en;
                    if (rd_en) begin
                        skid_data_d = mem_rdata;
                    end
                end else begin
                    out_valid_d = rd_en;
                    if (rd_en) begin
                        out_data_d = mem_rdata;
                    end
                end
            end else if (rd_en) begin
                skid_valid_d = 1'b1;
                skid_data_d  = mem_rdata;
            end
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            beat_cnt_q     <= '0;
            buffer_ready_q <= 1'b1;
            burst_done_q   <= 1'b0;
            overflow_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            skid_valid_q   <= 1'b0;
            skid_data_q    <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            beat_cnt_q     <= beat_cnt_d;
            buffer_ready_q <= buffer_ready_d;
            burst_done_q   <= burst_done_d;
            overflow_q     <= overflow_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            skid_valid_q   <= skid_valid_d;
            skid_data_q    <= skid_data_d;
        end
    end

    assign bus.buffer_ready = buffer_ready_q;
    assign bus.burst_done   = burst_done_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign level            = level_q;
    assign overflow         = overflow_q;

endmodule

`default_nettype wire
